// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

    typedef enum logic [1:0] {START, FETCH, HALT} fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/ifetch_ctrl_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries; flush wins over push/pop.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fetch_entry_t            wr_data,
    output fetch_entry_t            rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a full queue still accepts a push.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, queues ROM words, handles redirect/halt.
// Optional sticky bounds fault enabled by IFETCH_BOUNDS_CHECK_EN.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter int          MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MEM_WORDS < 1) begin : g_bad_cfg
        $error("ifetch_ctrl: DEPTH must be a power of two >= 2 and MEM_WORDS >= 1");
    end

    fetch_state_e state, state_nx;
    logic [31:0]  fetch_pc, pc_nx;
    logic         push, pop, flush, can_push;
    logic         redir_ok, resume_ok;
    logic         full, empty;
    logic [AW:0]  count;
    fetch_entry_t wr_entry, head;

`ifdef IFETCH_BOUNDS_CHECK_EN
    logic fault_q, fault_set, oob;
    assign redir_ok  = redirect_valid && !fault_q;
    assign resume_ok = !fault_q;
    assign oob       = ({2'b00, fetch_pc[31:2]} >= 32'(MEM_WORDS));
    assign fault     = fault_q;

    always_ff @(posedge clk) begin
        if (reset)          fault_q <= 1'b0;
        else if (fault_set) fault_q <= 1'b1;
    end
`else
    assign redir_ok  = redirect_valid;
    assign resume_ok = 1'b1;
    assign fault     = 1'b0;
`endif

    assign pop            = out_valid && out_ready;
    assign can_push       = (count < DEPTH_C) || pop;
    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = imem_instr;

    always_comb begin
        state_nx = state;
        pc_nx    = fetch_pc;
        push     = 1'b0;
        flush    = 1'b0;
`ifdef IFETCH_BOUNDS_CHECK_EN
        fault_set = 1'b0;
`endif
        unique case (state)
            START: state_nx = FETCH;
            FETCH: begin
                if (redir_ok) begin
                    flush = 1'b1;
                    pc_nx = redirect_pc & 32'hFFFF_FFFC;
                end else if (halt_req) begin
                    state_nx = HALT;
                end else if (can_push) begin
`ifdef IFETCH_BOUNDS_CHECK_EN
                    if (oob) begin
                        fault_set = 1'b1;
                        state_nx  = HALT;
                    end else
`endif
                    begin
                        push  = 1'b1;
                        pc_nx = fetch_pc + PC_STEP;
                    end
                end
            end
            HALT: begin
                if (redir_ok) begin
                    flush    = 1'b1;
                    pc_nx    = redirect_pc & 32'hFFFF_FFFC;
                    state_nx = FETCH;
                end else if (!halt_req && resume_ok) begin
                    state_nx = FETCH;
                end
            end
            default: state_nx = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= START;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nx;
            fetch_pc <= pc_nx;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) assert (full == (count == DEPTH_C));
    end

    assign imem_addr = fetch_pc;
    assign out_valid = !empty;
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : '0;
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl against a queue-based reference model.
module tb_ifetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          QD     = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic        halt_req = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
    logic        out_valid, halted, fault;
    logic [31:0] rom [64];

    int tests_run = 0;
    int failed = 0;

    bit          m_started, m_halted, m_fault;
    logic [31:0] m_pc;
    logic [63:0] mq [$];

    always #5 clk = ~clk;
    assign imem_instr = rom[imem_addr[7:2]];

    ifetch_ctrl #(.RESET_PC(RST_PC), .DEPTH(QD), .MEM_WORDS(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .fault          (fault)
    );

    // Reference model: applies the fetch rules to a plain queue once per clock edge.
    task automatic model_step();
        bit pop;
        if (reset) begin
            m_started = 0; m_halted = 0; m_fault = 0;
            m_pc = RST_PC;
            mq.delete();
        end else if (!m_started) begin
            m_started = 1;
        end else begin
            pop = (mq.size() != 0) && out_ready;
            if (redirect_valid && !m_fault) begin
                mq.delete();
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_halted = 0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (m_halted) begin
                    if (!halt_req && !m_fault) m_halted = 0;
                end else if (halt_req) begin
                    m_halted = 1;
                end else if (mq.size() < QD) begin
`ifdef IFETCH_BOUNDS_CHECK_EN
                    if (m_pc[31:2] >= 30'd64) begin
                        m_fault = 1; m_halted = 1;
                    end else
`endif
                    begin
                        mq.push_back({m_pc, rom[m_pc[7:2]]});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    endtask

    function automatic logic [98:0] expv();
        logic [63:0] h;
        logic        v;
        v = (mq.size() != 0);
        h = v ? mq[0] : 64'h0;
        return {v, h[63:32], h[31:0], m_pc, logic'(m_halted), logic'(m_fault)};
    endfunction

    function automatic logic [98:0] act();
        return {out_valid, out_pc, out_instr, imem_addr, halted, fault};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; redirect_valid = 0; halt_req = 0; out_ready = 0;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) rom[i] = i;
        reset = 1;
        tick(); tick();
        tests_run++;
        if ({out_valid, out_pc, out_instr, halted, fault} !== 67'h0 || imem_addr !== RST_PC) begin
            failed++;
            $display("FAIL reset: got v=%b pc=%h instr=%h halted=%b fault=%b addr=%h, want all 0 addr=%h",
                     out_valid, out_pc, out_instr, halted, fault, imem_addr, RST_PC);
        end
        tests_run++;
        if (act() !== expv()) begin
            failed++;
            $display("FAIL reset_model: got %h want %h", act(), expv());
        end
        reset = 0;
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests_run++;
            if (act() !== expv()) begin
                failed++;
                $display("FAIL stream_model k=%0d: got %h want %h", k, act(), expv());
            end
            if (k >= 2 && k <= 5) begin
                tests_run++;
                if (!out_valid || out_pc !== 32'((k - 2) * 4) || out_instr !== 32'(k - 2)) begin
                    failed++;
                    $display("FAIL stream k=%0d: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                             k, out_valid, out_pc, out_instr, 32'((k - 2) * 4), 32'(k - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (5) tick();
        tests_run++;
        if (!out_valid || out_pc !== 32'h0 || imem_addr !== 32'h8 || act() !== expv()) begin
            failed++;
            $display("FAIL bp_hold: got v=%b pc=%h addr=%h, want v=1 pc=0 addr=8", out_valid, out_pc, imem_addr);
        end
        out_ready = 1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            tests_run++;
            if (!out_valid || out_pc !== 32'(4 * k) || out_instr !== 32'(k) || act() !== expv()) begin
                failed++;
                $display("FAIL bp_drain k=%0d: got v=%b pc=%h instr=%h, want pc=%h instr=%h",
                         k, out_valid, out_pc, out_instr, 32'(4 * k), 32'(k));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (4) tick();
        redirect_valid = 1; redirect_pc = 32'h22;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h20 || act() !== expv()) begin
            failed++;
            $display("FAIL redirect_flush: got v=%b addr=%h, want v=0 addr=20", out_valid, imem_addr);
        end
        redirect_valid = 0;
        tick();
        tests_run++;
        if (!out_valid || out_pc !== 32'h20 || out_instr !== 32'd8 || act() !== expv()) begin
            failed++;
            $display("FAIL redirect_first: got v=%b pc=%h instr=%h, want v=1 pc=20 instr=8",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (4) tick();
        halt_req = 1; out_ready = 1;
        tick();
        tests_run++;
        if (!out_valid || out_pc !== 32'h4 || halted !== 1'b1 || imem_addr !== 32'h8 || act() !== expv()) begin
            failed++;
            $display("FAIL halt_drain1: got v=%b pc=%h halted=%b addr=%h, want 1/4/1/8", out_valid, out_pc, halted, imem_addr);
        end
        repeat (2) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'h8 || act() !== expv()) begin
                failed++;
                $display("FAIL halt_frozen: got v=%b halted=%b addr=%h, want 0/1/8", out_valid, halted, imem_addr);
            end
        end
        halt_req = 0;
        tick();
        tests_run++;
        if (halted !== 1'b0 || out_valid !== 1'b0 || act() !== expv()) begin
            failed++;
            $display("FAIL halt_exit: got halted=%b v=%b, want 0/0", halted, out_valid);
        end
        tick();
        tests_run++;
        if (!out_valid || out_pc !== 32'h8 || out_instr !== 32'd2 || act() !== expv()) begin
            failed++;
            $display("FAIL halt_resume: got v=%b pc=%h instr=%h, want 1/8/2", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_redirect_halt();
        do_reset();
        out_ready = 1;
        repeat (4) tick();
        redirect_valid = 1; halt_req = 1; redirect_pc = 32'h40;
        tick();
        tests_run++;
        if (halted !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h40 || act() !== expv()) begin
            failed++;
            $display("FAIL redir_over_halt: got halted=%b v=%b addr=%h, want 0/0/40", halted, out_valid, imem_addr);
        end
        redirect_valid = 0;
        tick();
        tests_run++;
        if (halted !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h40 || act() !== expv()) begin
            failed++;
            $display("FAIL halt_after_redir: got halted=%b v=%b addr=%h, want 1/0/40", halted, out_valid, imem_addr);
        end
        halt_req = 0;
        tick(); tick();
        tests_run++;
        if (!out_valid || out_pc !== 32'h40 || out_instr !== 32'd16 || act() !== expv()) begin
            failed++;
            $display("FAIL redir_resume: got v=%b pc=%h instr=%h, want 1/40/10", out_valid, out_pc, out_instr);
        end
        tick();
        reset = 1;
        tick();
        tests_run++;
        if ({out_valid, out_pc, out_instr, halted, fault} !== 67'h0 || imem_addr !== RST_PC || act() !== expv()) begin
            failed++;
            $display("FAIL mid_reset: got v=%b pc=%h instr=%h halted=%b addr=%h, want zeros addr=%h",
                     out_valid, out_pc, out_instr, halted, imem_addr, RST_PC);
        end
        reset = 0;
        tick(); tick();
        tests_run++;
        if (!out_valid || out_pc !== RST_PC || out_instr !== 32'd0 || act() !== expv()) begin
            failed++;
            $display("FAIL restart: got v=%b pc=%h instr=%h, want 1/%h/0", out_valid, out_pc, out_instr, RST_PC);
        end
    endtask

`ifdef IFETCH_BOUNDS_CHECK_EN
    task automatic test_bounds();
        do_reset();
        out_ready = 1;
        repeat (2) tick();
        redirect_valid = 1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 0;
        tick();
        tests_run++;
        if (fault !== 1'b1 || halted !== 1'b1 || out_valid !== 1'b0 || act() !== expv()) begin
            failed++;
            $display("FAIL bounds_fault: got fault=%b halted=%b v=%b, want 1/1/0", fault, halted, out_valid);
        end
        redirect_valid = 1; redirect_pc = 32'h0;
        repeat (2) tick();
        tests_run++;
        if (fault !== 1'b1 || halted !== 1'b1 || imem_addr !== 32'h100 || act() !== expv()) begin
            failed++;
            $display("FAIL bounds_sticky: got fault=%b halted=%b addr=%h, want 1/1/100", fault, halted, imem_addr);
        end
        do_reset();
        tests_run++;
        if (fault !== 1'b0 || halted !== 1'b0 || act() !== expv()) begin
            failed++;
            $display("FAIL bounds_clear: got fault=%b halted=%b, want 0/0", fault, halted);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            reset          = ($urandom_range(0, 99) < 2);
            out_ready      = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
            halt_req       = ($urandom_range(0, 99) < 12);
            tick();
            tests_run++;
            if (act() !== expv()) begin
                failed++;
                $display("FAIL random k=%0d: got %h want %h", k, act(), expv());
            end
        end
        reset = 0; redirect_valid = 0; halt_req = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_redirect_halt();
`ifdef IFETCH_BOUNDS_CHECK_EN
        test_bounds();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer for the 64-word asynchronous instruction ROM.
- Owns the fetch PC and drives the ROM address every cycle.
- Captures each returned word with its PC into a small FIFO and presents it to the pipeline decode stage over a valid/ready handshake.
- Handles decode back-pressure, branch redirects (with flush) and halt.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 2, fetch queue entries; must be a power of two, ≥2.
- MEM_WORDS, 64, ROM size in words; used only by the optional bounds check.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to the ROM; equals fetch_pc.
- imem_instr  in  32  ROM read data, combinational from imem_addr.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  32  byte address of the head instruction.
- redirect_valid  in  1  branch taken or flush request.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and forced to 0.
- halt_req  in  1  stop fetching; level-sensitive.
- halted  out  1  FSM is in HALT.
- fault  out  1  bounds fault, sticky; tied 0 when the optional feature is absent.

Behaviour:
- Reset state, one cycle after reset is high:
  - fetch_pc = RESET_PC; queue empty.
  - FSM = START.
  - out_valid = 0, out_instr = 0, out_pc = 0, halted = 0, fault = 0.
  - imem_addr = RESET_PC.
- Reset has priority over every other input, including mid-redirect and a full queue.
- FSM states: START, FETCH, HALT.
  - START → FETCH unconditionally after one cycle. No enqueue occurs in START.
  - FETCH → HALT when halt_req = 1 and redirect_valid = 0.
  - HALT → FETCH when halt_req = 0 or redirect_valid = 1.
- Enqueue in FETCH when (count < DEPTH or dequeue this cycle) and redirect_valid = 0 and halt_req = 0:
  - push {fetch_pc, imem_instr}; fetch_pc += 4.
  - Wraps modulo 2^32; no saturation.
- Dequeue: out_valid & out_ready pops the head. Simultaneous push and pop when full is allowed, and count stays DEPTH.
- Latency: ROM word at fetch_pc becomes visible on out_* the cycle after the enqueue edge. Throughput is 1 instruction/cycle while out_ready = 1.
- out_instr and out_pc hold stable while out_valid = 1 and out_ready = 0.
- Redirect, in any state except START:
  - on the edge, flush the queue (count = 0) and set fetch_pc = {redirect_pc[31:2], 2'b00}.
  - the same-cycle dequeue is discarded; no push.
  - out_valid = 0 the next cycle. The first redirected instruction appears 2 cycles after redirect assertion.
  - Redirect overrides halt_req for that cycle.
- HALT:
  - no pushes; existing queue entries still drain through the handshake.
  - halted = 1; fetch_pc frozen; imem_addr = fetch_pc.
- Counters:
  - rd/wr pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro IFETCH_BOUNDS_CHECK_EN.
- Defined:
  - a push attempt with fetch_pc[31:2] ≥ MEM_WORDS (redirect target included) does not push.
  - it sets fault = 1 (sticky until reset) and forces FSM → HALT.
  - HALT is then left only by reset. redirect_valid is ignored while fault = 1.
- Undefined:
  - no check; addresses wrap into the ROM by its own indexing.
  - fault is constant 0.

Decomposition:
- Package ifetch_pkg holds:
  - typedef enum logic [1:0] {START, FETCH, HALT} fetch_state_e;
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t;
  - localparam PC_STEP = 4.
- One sub-module is natural: fetch_fifo, a parameterized DEPTH-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, count.
  - flush has priority over push/pop.
  - Reset is synchronous.

Test Plan:
- Reset then out_ready = 1 for 6 cycles, ROM word n = n → out_pc 0,4,8,12 with out_instr 0,1,2,3 on consecutive cycles; first out_valid in cycle 3 after reset drops.
- out_ready = 0 for 5 cycles → queue fills to 2 entries; imem_addr holds 8; out_pc stays 0. Raising out_ready then yields 0,4,8 with no gaps or duplicates.
- redirect_valid with redirect_pc = 32'h22 while queue is full → next cycle out_valid = 0; 2 cycles later out_pc = 32'h20 and out_instr = word 8.
- halt_req = 1 with 2 entries queued, out_ready = 1 → both drain; halted = 1; imem_addr frozen. halt_req = 0 resumes at the next sequential PC.
- Simultaneous redirect_valid and halt_req → redirect taken; FSM stays/enters FETCH next cycle with halt honoured the following cycle; reset asserted mid-stream → all outputs 0 and fetch restarts at RESET_PC.
- With IFETCH_BOUNDS_CHECK_EN, redirect to 32'h100 → fault = 1, halted = 1, no push. A later redirect to 0 is ignored until reset.
